// File: rtl/cache_line_fill_axi_if.sv
// AXI4 read-address and read-data channels between the line-fill engine (master)
// and the instruction/data memory (slave).
interface cache_line_fill_axi_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Every channel transfers on the rising edge where valid and ready are both 1;
    // once raised, valid stays high with stable payload until that edge.
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/cache_line_fill_axi.sv
// Cache line-fill engine: takes one miss, issues one INCR burst for the whole line,
// assembles the beats and returns the line (with an error flag) to the cache.
module cache_line_fill_axi #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             miss_req_i,
    input  logic [ADDR_WIDTH-1:0]            miss_addr_i,
    output logic                             miss_gnt_o,
    output logic                             fill_valid_o,
    input  logic                             fill_ready_i,
    output logic [ADDR_WIDTH-1:0]            fill_addr_o,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] fill_data_o,
    output logic                             fill_err_o,
    output logic                             busy_o,
    output logic [1:0]                       dbg_state_o,
    cache_line_fill_axi_if.master            axi
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int              OFF_BITS  = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam int              CNT_W     = $clog2(LINE_WORDS) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LINE_WORDS);
    localparam logic [7:0]      AR_LEN    = 8'(LINE_WORDS - 1);
    localparam logic [2:0]      AR_SIZE   = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0]      AR_INCR   = 2'b01;

    state_t                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           line_addr_q;
    logic [LINE_WORDS*DATA_WIDTH-1:0] line_q;
    logic [CNT_W-1:0]                cnt_q;
    logic                            arvalid_q;
    logic                            rready_q;
    logic                            fill_valid_q;
    logic                            err_q;

    logic beat;
    logic err_set;
    logic fill_hs;

    // Next-state and per-cycle decode.
    always_comb begin
        state_d = state_q;
        beat    = rready_q & axi.m_axi_rvalid;
        fill_hs = fill_valid_q & fill_ready_i;
        // Bad response, early rlast, or a missing rlast on the last expected beat.
        err_set = beat & (axi.m_axi_rresp[1] |
                          (axi.m_axi_rlast & (cnt_q != LAST_IDX)) |
                          (~axi.m_axi_rlast & (cnt_q == LAST_IDX)));
        unique case (state_q)
            IDLE:    if (miss_req_i)             state_d = ADDR;
            ADDR:    if (axi.m_axi_arready)      state_d = DATA;
            DATA:    if (beat && axi.m_axi_rlast) state_d = DONE;
            DONE:    if (fill_hs)                state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // Control registers; valid/ready outputs are registered off the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            fill_valid_q <= 1'b0;
            line_addr_q  <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            arvalid_q    <= (state_d == ADDR);
            rready_q     <= (state_d == DATA);
            // The line is presented one cycle after DONE entry and dropped on handshake.
            fill_valid_q <= (state_q == DONE) && (state_d == DONE);
            if (state_q == IDLE && miss_req_i)
                line_addr_q <= {miss_addr_i[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
            if (state_q == ADDR && axi.m_axi_arready)
                cnt_q <= '0;
            else if (beat && cnt_q != FULL_CNT)
                cnt_q <= cnt_q + CNT_W'(1);
            if (fill_hs)
                err_q <= 1'b0;
            else if (err_set)
                err_q <= 1'b1;
        end
    end

    // Line buffer: beats past the line length never match a word index and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                if (beat && cnt_q == CNT_W'(i))
                    line_q[i*DATA_WIDTH +: DATA_WIDTH] <= axi.m_axi_rdata;
            end
        end
    end

    assign miss_gnt_o   = (state_q == IDLE) & miss_req_i;
    assign busy_o       = (state_q != IDLE);
    assign dbg_state_o  = state_q;
    assign fill_valid_o = fill_valid_q;
    assign fill_addr_o  = line_addr_q;
    assign fill_data_o  = line_q;
    assign fill_err_o   = fill_valid_q & err_q;

    assign axi.m_axi_araddr  = line_addr_q;
    assign axi.m_axi_arvalid = arvalid_q;
    assign axi.m_axi_arlen   = arvalid_q ? AR_LEN  : 8'd0;
    assign axi.m_axi_arsize  = arvalid_q ? AR_SIZE : 3'd0;
    assign axi.m_axi_arburst = arvalid_q ? AR_INCR : 2'd0;
    assign axi.m_axi_rready  = rready_q;

endmodule

// File: tb/tb_cache_line_fill_axi.sv
// Directed bench for cache_line_fill_axi: a scripted AXI slave (word = address/4)
// and hand-computed line contents, latencies and error flags.
module tb_cache_line_fill_axi;

    logic         clk;
    logic         rst_n;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         miss_gnt;
    logic         fill_valid;
    logic         fill_ready;
    logic [31:0]  fill_addr;
    logic [127:0] fill_data;
    logic         fill_err;
    logic         busy;
    logic [1:0]   dbg_state;
    int           cyc;
    int           n_vec;
    int           n_err;
    int           g_cyc;

    cache_line_fill_axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi_bus ();

    cache_line_fill_axi #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .miss_req_i   (miss_req),
        .miss_addr_i  (miss_addr),
        .miss_gnt_o   (miss_gnt),
        .fill_valid_o (fill_valid),
        .fill_ready_i (fill_ready),
        .fill_addr_o  (fill_addr),
        .fill_data_o  (fill_data),
        .fill_err_o   (fill_err),
        .busy_o       (busy),
        .dbg_state_o  (dbg_state),
        .axi          (axi_bus)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Grant a miss, serve the AR channel, then stream nbeats beats of word = address/4.
    task automatic issue_and_burst(input logic [31:0] addr, input logic [31:0] line,
                                   input int ar_delay, input int nbeats,
                                   input bit toggle, input int err_beat);
        int beat;
        int phase;
        bit v;
        miss_req  = 1'b1;
        miss_addr = addr;
        #1;
        chk("miss_gnt", miss_gnt, 1);
        g_cyc = cyc;
        tick();
        miss_req = 1'b0;
        chk("arvalid", axi_bus.m_axi_arvalid, 1);
        chk("araddr", axi_bus.m_axi_araddr, line);
        chk("arlen", axi_bus.m_axi_arlen, 3);
        chk("arsize", axi_bus.m_axi_arsize, 2);
        chk("arburst", axi_bus.m_axi_arburst, 1);
        for (int d = 0; d < ar_delay; d++) begin
            axi_bus.m_axi_arready = 1'b0;
            tick();
            chk("arvalid_hold", axi_bus.m_axi_arvalid, 1);
            chk("araddr_hold", axi_bus.m_axi_araddr, line);
        end
        axi_bus.m_axi_arready = 1'b1;
        tick();
        axi_bus.m_axi_arready = 1'b0;
        beat  = 0;
        phase = 0;
        while (beat < nbeats && phase < 100) begin
            v = toggle ? (phase % 2 == 0) : 1'b1;
            axi_bus.m_axi_rvalid = v;
            axi_bus.m_axi_rdata  = line / 4 + beat;
            axi_bus.m_axi_rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
            axi_bus.m_axi_rlast  = (beat == nbeats - 1);
            if (v) chk("rready_beat", axi_bus.m_axi_rready, 1);
            tick();
            if (v) beat++;
            phase++;
        end
        chk("burst_done", beat, nbeats);
        axi_bus.m_axi_rvalid = 1'b0;
        axi_bus.m_axi_rlast  = 1'b0;
        axi_bus.m_axi_rresp  = 2'b00;
        chk("rready_drop", axi_bus.m_axi_rready, 0);
    endtask

    task automatic wait_fill();
        int n;
        n = 0;
        while (!fill_valid && n < 20) begin
            tick();
            n++;
        end
        chk("fill_valid", fill_valid, 1);
    endtask

    task automatic check_fill(input logic [31:0] line, input logic [127:0] data, input logic err);
        chk("fill_addr", fill_addr, line);
        chk("fill_data", fill_data, data);
        chk("fill_err", fill_err, err);
    endtask

    task automatic accept_fill();
        fill_ready = 1'b1;
        tick();
        fill_ready = 1'b0;
        chk("valid_after_hs", fill_valid, 0);
        chk("busy_after_hs", busy, 0);
    endtask

    localparam logic [127:0] LINE_A = 128'h00040007_00040006_00040005_00040004;
    localparam logic [127:0] LINE_B = 128'h00000043_00000042_00000041_00000040;

    initial begin
        n_vec = 0;
        n_err = 0;
        g_cyc = 0;
        rst_n = 1'b0;
        miss_req = 1'b0;
        miss_addr = '0;
        fill_ready = 1'b0;
        axi_bus.m_axi_arready = 1'b0;
        axi_bus.m_axi_rvalid  = 1'b0;
        axi_bus.m_axi_rdata   = '0;
        axi_bus.m_axi_rresp   = 2'b00;
        axi_bus.m_axi_rlast   = 1'b0;

        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_arvalid", axi_bus.m_axi_arvalid, 0);
        chk("rst_arlen", axi_bus.m_axi_arlen, 0);
        chk("rst_fill_data", fill_data, 0);
        chk("rst_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Zero-wait fill and latency
        issue_and_burst(32'h0010_0014, 32'h0010_0010, 0, 4, 1'b0, -1);
        wait_fill();
        chk("latency", cyc - g_cyc, 7);
        check_fill(32'h0010_0010, LINE_A, 1'b0);
        accept_fill();

        // Delayed arready, toggling rvalid
        issue_and_burst(32'h0010_0014, 32'h0010_0010, 5, 4, 1'b1, -1);
        wait_fill();
        check_fill(32'h0010_0010, LINE_A, 1'b0);
        accept_fill();

        // SLVERR on beat 2, then a clean fill clears the error
        issue_and_burst(32'h0010_0014, 32'h0010_0010, 0, 4, 1'b0, 2);
        wait_fill();
        check_fill(32'h0010_0010, LINE_A, 1'b1);
        accept_fill();
        issue_and_burst(32'h0000_0104, 32'h0000_0100, 1, 4, 1'b0, -1);
        wait_fill();
        check_fill(32'h0000_0100, LINE_B, 1'b0);
        accept_fill();

        // Short burst: word 3 keeps the previous line's value
        issue_and_burst(32'h0000_0208, 32'h0000_0200, 0, 3, 1'b0, -1);
        wait_fill();
        check_fill(32'h0000_0200, 128'h00000043_00000082_00000081_00000080, 1'b1);
        accept_fill();

        // Long burst: beats 4 and 5 discarded, rready held until rlast
        issue_and_burst(32'h0000_030C, 32'h0000_0300, 0, 6, 1'b0, -1);
        wait_fill();
        check_fill(32'h0000_0300, 128'h000000C3_000000C2_000000C1_000000C0, 1'b1);
        accept_fill();

        // Back-pressure on the fill port with a pending miss
        issue_and_burst(32'h0010_0014, 32'h0010_0010, 0, 4, 1'b0, -1);
        wait_fill();
        miss_req  = 1'b1;
        miss_addr = 32'h0000_0104;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("hold_gnt", miss_gnt, 0);
            chk("hold_valid", fill_valid, 1);
            chk("hold_data", fill_data, LINE_A);
            chk("hold_addr", fill_addr, 32'h0010_0010);
            tick();
        end
        fill_ready = 1'b1;
        #1;
        chk("hs_gnt", miss_gnt, 0);
        tick();
        fill_ready = 1'b0;
        issue_and_burst(32'h0000_0104, 32'h0000_0100, 0, 4, 1'b0, -1);
        wait_fill();
        check_fill(32'h0000_0100, LINE_B, 1'b0);
        accept_fill();

        // Reset during beat 1
        miss_req  = 1'b1;
        miss_addr = 32'h0010_0014;
        #1;
        chk("rst_mid_gnt", miss_gnt, 1);
        tick();
        miss_req = 1'b0;
        axi_bus.m_axi_arready = 1'b1;
        tick();
        axi_bus.m_axi_arready = 1'b0;
        axi_bus.m_axi_rvalid = 1'b1;
        axi_bus.m_axi_rdata  = 32'h0004_0004;
        tick();
        axi_bus.m_axi_rdata  = 32'h0004_0005;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rready", axi_bus.m_axi_rready, 0);
        chk("mid_rst_arvalid", axi_bus.m_axi_arvalid, 0);
        chk("mid_rst_araddr", axi_bus.m_axi_araddr, 0);
        chk("mid_rst_fill_valid", fill_valid, 0);
        chk("mid_rst_fill_addr", fill_addr, 0);
        chk("mid_rst_fill_data", fill_data, 0);
        chk("mid_rst_fill_err", fill_err, 0);
        chk("mid_rst_state", dbg_state, 0);
        axi_bus.m_axi_rvalid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        issue_and_burst(32'h0010_0014, 32'h0010_0010, 0, 4, 1'b0, -1);
        wait_fill();
        check_fill(32'h0010_0010, LINE_A, 1'b0);
        accept_fill();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_line_fill_axi.md
Name: cache_line_fill_axi

Overview:
- AXI4 read-master line-fill engine for the n-way set-associative cache in the Kuuga simulation system.
- Sits between the cache miss logic (upstream) and the AXI memory slave (downstream, the data or instruction memory).
- Accepts one miss address, issues a single INCR burst for the whole line, assembles the beats, and hands a complete line back to the cache.
- Flags AXI error responses and burst-length violations.

Parameters:
ADDR_WIDTH, 32, AXI address and miss address width
DATA_WIDTH, 32, AXI read data width; must be 32 or 64
LINE_WORDS, 4, DATA_WIDTH words per cache line; power of 2, 2..16

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
miss_req_i  in  1  miss request valid
miss_addr_i  in  ADDR_WIDTH  byte address of the missing access
miss_gnt_o  out  1  request accepted this cycle
fill_valid_o  out  1  line available
fill_ready_i  in  1  cache accepts line
fill_addr_o  out  ADDR_WIDTH  line-aligned base address of the returned line
fill_data_o  out  LINE_WORDS*DATA_WIDTH  line data; word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
fill_err_o  out  1  line invalid (error response or length violation); qualifies fill_valid_o
busy_o  out  1  engine not in IDLE
m_axi_araddr  out  ADDR_WIDTH  burst start address
m_axi_arlen  out  8  burst length field
m_axi_arsize  out  3  beat size field
m_axi_arburst  out  2  burst type
m_axi_arvalid  out  1  AR channel valid
m_axi_arready  in  1  AR channel ready
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat
m_axi_rvalid  in  1  R channel valid
m_axi_rready  out  1  R channel ready

Behaviour:
- Reset (async assert on rst_n=0): state IDLE. All outputs are 0, including fill_data_o, fill_addr_o, m_axi_* and the beat counter. The sticky error is cleared.
- Constant fields while arvalid=1:
  - arlen = LINE_WORDS-1.
  - arsize = log2(DATA_WIDTH/8).
  - arburst = 2'b01 (INCR).
- IDLE:
  - miss_gnt_o = miss_req_i (combinational).
  - On miss_req_i=1, capture line_addr = miss_addr_i with the low log2(LINE_WORDS*DATA_WIDTH/8) bits cleared, then go to ADDR.
- ADDR:
  - m_axi_arvalid=1 and m_axi_araddr=line_addr, both registered, so arvalid rises exactly 1 cycle after the grant.
  - araddr and the other AR fields stay stable until the handshake; arvalid is never withdrawn.
  - On arready=1, go to DATA with beat counter = 0.
- DATA:
  - m_axi_rready=1 (registered, asserted on DATA entry).
  - Each rvalid&rready beat:
    - If counter < LINE_WORDS, write rdata into word[counter].
    - Increment the counter, saturating at LINE_WORDS.
    - If rresp is SLVERR (2'b10) or DECERR (2'b11), set the sticky error.
  - Length check:
    - rlast on a beat where counter != LINE_WORDS-1 sets the sticky error.
    - A beat arriving with counter == LINE_WORDS-1 but rlast=0 sets the sticky error; subsequent beats are discarded.
  - Exit: leave DATA on the beat with rlast=1, never before, so the AXI transaction always completes. The next state is DONE, rready drops the cycle after rlast.
- DONE:
  - fill_valid_o=1, fill_addr_o=line_addr, fill_data_o=assembled line, fill_err_o=sticky error.
  - Outputs are held stable until fill_ready_i=1.
  - On handshake, go to IDLE next cycle and clear the sticky error. fill_valid_o falls with the IDLE transition.
  - No new miss is granted in DONE or in the handshake cycle; the earliest next grant is the cycle after the handshake.
- Latency: with arready and rvalid always 1 and fill_ready_i=1, fill_valid_o rises LINE_WORDS+3 cycles after the grant cycle.
- busy_o = (state != IDLE).
- One outstanding burst only. miss_req_i is ignored outside IDLE, and miss_gnt_o=0 there.
- fill_data_o words not written in a short burst keep the previous line's value; fill_err_o=1 marks the line unusable.
- Reset mid-burst:
  - The engine abandons the burst and all state.
  - The downstream slave must be reset concurrently. The system-level reset does this.

Test Plan:
- LINE_WORDS=4, miss_addr_i=0x0010_0014, zero-wait slave (memory word = address/4) -> m_axi_araddr=0x0010_0010, arlen=3, arsize=2, arburst=1. fill_data_o={0x00040007,0x00040006,0x00040005,0x00040004}, fill_err_o=0, fill_valid_o at cycle grant+7.
- arready delayed 5 cycles, rvalid toggling 1/0 per cycle -> araddr and arvalid stable throughout. Same line data as above. No beat lost or duplicated.
- Beat 2 returns rresp=2'b10 -> all 4 beats consumed, rlast honoured, fill_err_o=1; the next clean fill reports fill_err_o=0.
- Slave asserts rlast on beat 2 (3 beats) -> fill_err_o=1, return to IDLE after the handshake; a 6-beat burst also gives fill_err_o=1, extra beats discarded, rready held until rlast.
- fill_ready_i held 0 for 10 cycles while miss_req_i=1 -> fill outputs stable, miss_gnt_o=0 throughout. The grant occurs the cycle after the fill_ready_i handshake.
- rst_n pulsed low during DATA beat 1 -> all outputs 0 asynchronously, busy_o=0. A fresh miss after release completes normally.
